instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Parametrised instruction fetch/decode/issue controller for the uTPU datapath. It pulls bytes from the first-word-fall-through RX FIFO and assembles them into INSTR_WIDTH instruction words. Each decoded command is issued to the execution side over a valid/ready handshake, and the sequencer then waits for that unit's completion pulse. Compared with the previous controller, it adds generic word and address widths, an optional extended-address operand, illegal-opcode detection, a completion timeout, and a halt/resume mechanism.

Parameters:
INSTR_WIDTH, 16, instruction word width in bits; must be >= OPCODE_WIDTH+3+ADDRESS_SIZE
BYTE_WIDTH, 8, RX FIFO data width
OPCODE_WIDTH, 3, opcode field width
ADDRESS_SIZE, 10, unified buffer address width
TIMEOUT_CYCLES, 1024, maximum WAIT_DONE cycles before abort; must be >= 1
(derived) INSTR_BYTES = ceil(INSTR_WIDTH/BYTE_WIDTH); ADDR_BYTES = ceil(ADDRESS_SIZE/BYTE_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; leaves IDLE
resume  in  1  pulse; leaves HALT
rx_data  in  BYTE_WIDTH  FIFO head byte, valid while ~rx_empty
rx_empty  in  1  FIFO empty flag
rx_re  out  1  FIFO pop; combinational
cmd_valid  out  1  command valid
cmd_ready  in  1  execution side accepts the command
cmd_opcode  out  OPCODE_WIDTH  decoded opcode
cmd_flags  out  3  instr[OPCODE_WIDTH+2:OPCODE_WIDTH]
cmd_address  out  ADDRESS_SIZE  buffer address
exec_done  in  1  completion pulse from the issued unit
busy  out  1  high whenever state != IDLE and state != HALT
halted  out  1  high in HALT
err_illegal  out  1  sticky: illegal opcode seen
err_timeout  out  1  sticky: completion timeout occurred
err_clr  in  1  clears both sticky error flags
instr_count  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, state IDLE, assembly byte index 0, timeout counter 0. Reset asserted mid-operation discards any partial word and any pending command; no pop occurs while rst is high.
- States: IDLE, FETCH, EXT_ADDR, ISSUE, WAIT_DONE, HALT.
- IDLE: moves to FETCH on start. start is ignored in every other state.
- rx_re = (state==FETCH || state==EXT_ADDR) && ~rx_empty. One byte is popped per cycle. An empty FIFO stalls the sequencer indefinitely with no error.
- Assembly is little-endian: byte k lands in bits [k*BYTE_WIDTH +: BYTE_WIDTH]. Bits beyond INSTR_WIDTH (or ADDRESS_SIZE for the address operand) are discarded.
- Field layout: opcode = instr[OPCODE_WIDTH-1:0]; flags = the next 3 bits; address = instr[INSTR_WIDTH-1 -: ADDRESS_SIZE].
- Opcode encoding: 0 STORE, 1 FETCH, 2 RUN, 3 LOAD, 4 HALT, 5 NOP, all others illegal.
- On the edge that pops the last instruction byte, the word is decoded. Next state by opcode:
  - STORE with flags[1]=1: EXT_ADDR, which pops ADDR_BYTES more bytes; that value replaces cmd_address, then the state moves to ISSUE.
  - HALT: moves to HALT.
  - NOP: stays in FETCH, counts as retired, no command issued.
  - Illegal opcode: sets err_illegal, stays in FETCH, not retired, no command issued.
  - Otherwise: ISSUE.
- cmd_valid is registered. It is first high in the cycle after the final byte pop, i.e. two cycles after the first pop for a 2-byte instruction.
- ISSUE: cmd_valid and all cmd_* fields are held stable until cmd_valid && cmd_ready, then the state moves to WAIT_DONE. cmd_valid drops on the following cycle.
- WAIT_DONE: exec_done is sampled starting the cycle after the handshake; a pulse coincident with the handshake is ignored. On exec_done: retire, move to FETCH, clear the counter. If the counter reaches TIMEOUT_CYCLES without exec_done: set err_timeout, do not retire, move to FETCH.
- HALT: retired on entry; halted=1; no pops. resume moves to FETCH.
- err_clr has priority over a same-cycle error set.

Optional Feature:
INSTR_COUNT_EN
- Defined: instr_count is a 32-bit wrapping counter that increments once per retired instruction (NOP, HALT, or a completed command).
- Undefined: instr_count is tied to 0 and the counter logic is not synthesised.

Test Plan:
- RUN: FIFO holds 0x2A,0x10; pulse start; cmd_ready=1 -> cmd_valid two cycles after the first pop with opcode=2, flags=5, address=0x040; exec_done 3 cycles later -> busy stays 1, state returns to FETCH, instr_count=1.
- Extended STORE: bytes 0x10,0x00,0xFF,0x07 -> single command with opcode=0, flags=2, address=0x3FF (bits above ADDRESS_SIZE dropped); exactly 4 pops.
- Illegal and NOP: bytes 0x07,0x00,0x05,0x00,0x01,0x00 -> err_illegal=1, no cmd_valid for the first two words, one FETCH command issued; err_clr -> err_illegal=0.
- Backpressure and timeout: TIMEOUT_CYCLES=16; cmd_ready held 0 for 5 cycles -> fields stable throughout; after the handshake, no exec_done -> err_timeout=1 exactly 16 cycles later, instr_count unchanged.
- HALT: bytes 0x04,0x00,0x05,0x00 -> halted=1, rx_re=0 while the FIFO is non-empty; pulse resume -> NOP consumed, instr_count=2.
- Reset mid-fetch: pop 0x2A, assert rst for 2 cycles, then feed 0x03,0x10 after start -> LOAD with address=0x040; the stale byte is not used.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction fetch/decode/issue controller: assembles RX FIFO bytes into words and issues commands.
// Optional retired-instruction counter is compiled in with `define INSTR_COUNT_EN.
module instr_sequencer #(
   parameter int INSTR_WIDTH    = 16,
   parameter int BYTE_WIDTH     = 8,
   parameter int OPCODE_WIDTH   = 3,
   parameter int ADDRESS_SIZE   = 10,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    resume,
   input  logic [BYTE_WIDTH-1:0]   rx_data,
   input  logic                    rx_empty,
   output logic                    rx_re,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic [OPCODE_WIDTH-1:0] cmd_opcode,
   output logic [2:0]              cmd_flags,
   output logic [ADDRESS_SIZE-1:0] cmd_address,
   input  logic                    exec_done,
   output logic                    busy,
   output logic                    halted,
   output logic                    err_illegal,
   output logic                    err_timeout,
   input  logic                    err_clr,
   output logic [31:0]             instr_count
);
   localparam int INSTR_BYTES = (INSTR_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
   localparam int ADDR_BYTES  = (ADDRESS_SIZE + BYTE_WIDTH - 1) / BYTE_WIDTH;
   localparam int MAX_BYTES   = (INSTR_BYTES > ADDR_BYTES) ? INSTR_BYTES : ADDR_BYTES;
   localparam int IDX_W       = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam int CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam int ASM_W       = MAX_BYTES * BYTE_WIDTH;

   localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_FETCH = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_RUN   = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(5);

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_EXT_ADDR, ST_ISSUE, ST_WAIT_DONE, ST_HALT
   } state_t;

   state_t                  state_reg, state_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic [ASM_W-1:0]        asm_reg, asm_next;
   logic                    valid_reg, valid_next;
   logic [OPCODE_WIDTH-1:0] opcode_reg, opcode_next;
   logic [2:0]              flags_reg, flags_next;
   logic [ADDRESS_SIZE-1:0] address_reg, address_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic                    err_illegal_reg, err_timeout_reg;
   logic                    set_illegal, set_timeout, retire, latch_fields;

   // Word as it will look once the byte at the FIFO head lands in the current lane.
   logic [ASM_W-1:0] word_cur;
   generate
      for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
         assign word_cur[gi*BYTE_WIDTH +: BYTE_WIDTH] =
            (idx_reg == IDX_W'(gi)) ? rx_data : asm_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
   endgenerate

   logic [OPCODE_WIDTH-1:0] dec_opcode;
   logic [2:0]              dec_flags;
   logic [ADDRESS_SIZE-1:0] dec_address, ext_address;
   assign dec_opcode  = word_cur[OPCODE_WIDTH-1:0];
   assign dec_flags   = word_cur[OPCODE_WIDTH+2:OPCODE_WIDTH];
   assign dec_address = word_cur[INSTR_WIDTH-1 -: ADDRESS_SIZE];
   assign ext_address = word_cur[ADDRESS_SIZE-1:0];

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      asm_next     = asm_reg;
      valid_next   = valid_reg;
      opcode_next  = opcode_reg;
      flags_next   = flags_reg;
      address_next = address_reg;
      cnt_next     = cnt_reg;
      set_illegal  = 1'b0;
      set_timeout  = 1'b0;
      retire       = 1'b0;
      latch_fields = 1'b0;
      rx_re        = 1'b0;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_FETCH;
         ST_FETCH: begin
            if (!rx_empty) begin
               rx_re    = 1'b1;
               asm_next = word_cur;
               if (idx_reg == IDX_W'(INSTR_BYTES - 1)) begin
                  idx_next = '0;
                  case (dec_opcode)
                     OP_STORE: begin
                        latch_fields = 1'b1;
                        if (dec_flags[1]) begin
                           state_next = ST_EXT_ADDR;
                        end else begin
                           state_next = ST_ISSUE;
                           valid_next = 1'b1;
                        end
                     end
                     OP_FETCH, OP_RUN, OP_LOAD: begin
                        latch_fields = 1'b1;
                        state_next   = ST_ISSUE;
                        valid_next   = 1'b1;
                     end
                     OP_HALT: begin
                        retire     = 1'b1;
                        state_next = ST_HALT;
                     end
                     OP_NOP:  retire = 1'b1;
                     default: set_illegal = 1'b1;
                  endcase
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end
         end
         ST_EXT_ADDR: begin
            if (!rx_empty) begin
               rx_re    = 1'b1;
               asm_next = word_cur;
               if (idx_reg == IDX_W'(ADDR_BYTES - 1)) begin
                  idx_next     = '0;
                  address_next = ext_address;
                  valid_next   = 1'b1;
                  state_next   = ST_ISSUE;
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               valid_next = 1'b0;
               cnt_next   = '0;
               state_next = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (exec_done) begin
               retire     = 1'b1;
               cnt_next   = '0;
               state_next = ST_FETCH;
            end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               set_timeout = 1'b1;
               cnt_next    = '0;
               state_next  = ST_FETCH;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_HALT: if (resume) state_next = ST_FETCH;
         default: state_next = ST_IDLE;
      endcase
      if (latch_fields) begin
         opcode_next  = dec_opcode;
         flags_next   = dec_flags;
         address_next = dec_address;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         idx_reg         <= '0;
         asm_reg         <= '0;
         valid_reg       <= 1'b0;
         opcode_reg      <= '0;
         flags_reg       <= '0;
         address_reg     <= '0;
         cnt_reg         <= '0;
         err_illegal_reg <= 1'b0;
         err_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         idx_reg         <= idx_next;
         asm_reg         <= asm_next;
         valid_reg       <= valid_next;
         opcode_reg      <= opcode_next;
         flags_reg       <= flags_next;
         address_reg     <= address_next;
         cnt_reg         <= cnt_next;
         // Clearing wins over a same-cycle error event.
         err_illegal_reg <= err_clr ? 1'b0 : (err_illegal_reg | set_illegal);
         err_timeout_reg <= err_clr ? 1'b0 : (err_timeout_reg | set_timeout);
      end
   end

   assign cmd_valid   = valid_reg;
   assign cmd_opcode  = opcode_reg;
   assign cmd_flags   = flags_reg;
   assign cmd_address = address_reg;
   assign err_illegal = err_illegal_reg;
   assign err_timeout = err_timeout_reg;
   assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
   assign halted      = (state_reg == ST_HALT);

`ifdef INSTR_COUNT_EN
   logic [31:0] count_reg;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         count_reg <= '0;
      else if (retire) count_reg <= count_reg + 32'd1;
   end
   assign instr_count = count_reg;
`else
   logic retire_unused;
   assign retire_unused = retire;
   assign instr_count   = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scenarios plus a randomized instruction stream checked against an instruction-level model.
`timescale 1ns/1ps
module tb_instr_sequencer;
   localparam int TO = 16;
`ifdef INSTR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] fl;
      logic [9:0] ad;
   } cmd_t;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, resume = 1'b0;
   logic        cmd_ready = 1'b0, exec_done = 1'b0, err_clr = 1'b0;
   logic        rx_empty, rx_re, cmd_valid, busy, halted, err_illegal, err_timeout;
   logic [7:0]  rx_data;
   logic [2:0]  cmd_opcode, cmd_flags;
   logic [9:0]  cmd_address;
   logic [31:0] instr_count;

   logic [7:0]  fifo_mem [0:255];
   int wp = 0;
   int rp = 0;
   int checks = 0;
   int failures = 0;
   int retired = 0;

   int base, nvalid, n, cyc, timer, n_illegal, n_retire_only, exp_total;
   logic [2:0]  seen_op, op, fl;
   logic [9:0]  ad;
   logic [15:0] word, ext;
   cmd_t        e;
   cmd_t        exp_q[$];
   logic [7:0]  stream[$];

   assign rx_empty = (rp == wp);
   assign rx_data  = fifo_mem[8'(rp)];

   always @(posedge clk) if (rx_re) rp <= rp + 1;
   always #5 clk = ~clk;

   instr_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .resume(resume),
      .rx_data(rx_data), .rx_empty(rx_empty), .rx_re(rx_re),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_flags(cmd_flags), .cmd_address(cmd_address), .exec_done(exec_done),
      .busy(busy), .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout),
      .err_clr(err_clr), .instr_count(instr_count)
   );

   task automatic tick(input int k = 1);
      repeat (k) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      fifo_mem[8'(wp)] = b;
      wp = wp + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_count(input string tag);
      check(tag, instr_count, CNT_EN ? 32'(retired) : 32'd0);
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!cmd_valid && k < 40) begin
         tick();
         k++;
      end
      check(tag, 32'(cmd_valid), 32'd1);
   endtask

   task automatic pulse_done();
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(2);
      check("rst_valid",   32'(cmd_valid),   32'd0);
      check("rst_busy",    32'(busy),        32'd0);
      check("rst_halted",  32'(halted),      32'd0);
      check("rst_err_ill", 32'(err_illegal), 32'd0);
      check("rst_err_to",  32'(err_timeout), 32'd0);
      check("rst_count",   instr_count,      32'd0);
      rst = 1'b0;
      tick();

      // RUN: 0x2A,0x10 -> opcode 2, flags 5, address 0x040
      cmd_ready = 1'b1;
      push(8'h2A); push(8'h10);
      tick();
      check("idle_no_pop", 32'(rx_re), 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      check("t1_first_pop", 32'(rx_re), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      tick();
      check("t1_valid_early", 32'(cmd_valid), 32'd0);
      tick();
      check("t1_valid",  32'(cmd_valid),   32'd1);
      check("t1_opcode", 32'(cmd_opcode),  32'd2);
      check("t1_flags",  32'(cmd_flags),   32'd5);
      check("t1_addr",   32'(cmd_address), 32'h040);
      check("t1_pops",   32'(rp),          32'd2);
      tick();
      check("t1_valid_drop", 32'(cmd_valid), 32'd0);
      tick(2);
      pulse_done(); retired++;
      check("t1_busy_after", 32'(busy), 32'd1);
      check_count("t1_count");

      // Extended-address STORE
      cmd_ready = 1'b0; base = rp;
      push(8'h10); push(8'h00); push(8'hFF); push(8'h07);
      wait_valid("t2_valid");
      check("t2_opcode", 32'(cmd_opcode),  32'd0);
      check("t2_flags",  32'(cmd_flags),   32'd2);
      check("t2_addr",   32'(cmd_address), 32'h3FF);
      check("t2_pops",   32'(rp - base),   32'd4);
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      check("t2_valid_drop", 32'(cmd_valid), 32'd0);
      pulse_done(); retired++;
      check_count("t2_count");

      // Illegal, NOP, FETCH
      cmd_ready = 1'b1; base = rp; nvalid = 0; seen_op = 3'd7;
      push(8'h07); push(8'h00); push(8'h05); push(8'h00); push(8'h01); push(8'h00);
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cmd_valid) begin
            nvalid++;
            seen_op = cmd_opcode;
         end
      end
      check("t3_num_cmds", 32'(nvalid),      32'd1);
      check("t3_opcode",   32'(seen_op),     32'd1);
      check("t3_err_ill",  32'(err_illegal), 32'd1);
      check("t3_pops",     32'(rp - base),   32'd6);
      pulse_done(); retired += 2;
      check_count("t3_count");
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("t3_err_clr", 32'(err_illegal), 32'd0);

      // err_clr coincident with an illegal decode
      base = rp;
      push(8'h07); push(8'h00);
      tick();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("clr_prio_pops", 32'(rp - base),   32'd2);
      check("clr_prio_err",  32'(err_illegal), 32'd0);

      // Backpressure, ignored coincident done, then timeout
      cmd_ready = 1'b0;
      push(8'h03); push(8'h10);
      wait_valid("t4_valid");
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", 32'(cmd_valid),   32'd1);
         check("t4_hold_op",    32'(cmd_opcode),  32'd3);
         check("t4_hold_flags", 32'(cmd_flags),   32'd0);
         check("t4_hold_addr",  32'(cmd_address), 32'h040);
         tick();
      end
      cmd_ready = 1'b1; exec_done = 1'b1;
      tick();
      cmd_ready = 1'b0; exec_done = 1'b0;
      check("t4_valid_drop", 32'(cmd_valid), 32'd0);
      tick(TO - 1);
      check("t4_no_timeout_yet", 32'(err_timeout), 32'd0);
      tick();
      check("t4_timeout", 32'(err_timeout), 32'd1);
      check("t4_busy",    32'(busy),        32'd1);
      check_count("t4_count");
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("t4_err_clr", 32'(err_timeout), 32'd0);

      // HALT and resume
      base = rp;
      push(8'h04); push(8'h00); push(8'h05); push(8'h00);
      n = 0;
      while (!halted && n < 20) begin
         tick();
         n++;
      end
      check("t5_halted", 32'(halted), 32'd1);
      retired++;
      check("t5_busy",  32'(busy),      32'd0);
      check("t5_no_re", 32'(rx_re),     32'd0);
      check("t5_pops",  32'(rp - base), 32'd2);
      check_count("t5_count");
      start = 1'b1; tick(); start = 1'b0; tick();
      check("t5_start_ignored", 32'(halted),    32'd1);
      check("t5_still_no_pop",  32'(rp - base), 32'd2);
      resume = 1'b1; tick(); resume = 1'b0;
      tick(3);
      retired++;
      check("t5_resume_pops",   32'(rp - base), 32'd4);
      check("t5_resume_halted", 32'(halted),    32'd0);
      check_count("t5_resume_count");

      // Reset in the middle of a word
      base = rp;
      push(8'h2A);
      tick();
      check("t6_stale_pop", 32'(rp - base), 32'd1);
      rst = 1'b1; retired = 0;
      tick();
      check("t6_rst_re",    32'(rx_re), 32'd0);
      check("t6_rst_busy",  32'(busy),  32'd0);
      check_count("t6_rst_count");
      tick();
      rst = 1'b0;
      push(8'h03); push(8'h10);
      tick();
      check("t6_idle_no_pop", 32'(rx_re), 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      wait_valid("t6_valid");
      check("t6_opcode", 32'(cmd_opcode),  32'd3);
      check("t6_flags",  32'(cmd_flags),   32'd0);
      check("t6_addr",   32'(cmd_address), 32'h040);
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      pulse_done(); retired++;
      check_count("t6_count");

      // Randomized stream against an instruction-level model
      n_illegal = 0; n_retire_only = 0;
      for (int k = 0; k < 40; k++) begin
         op   = 3'($urandom_range(0, 7));
         fl   = 3'($urandom_range(0, 7));
         ad   = 10'($urandom_range(0, 1023));
         word = {ad, fl, op};
         stream.push_back(word[7:0]);
         stream.push_back(word[15:8]);
         e.op = op; e.fl = fl; e.ad = ad;
         if (op == 3'd0 && fl[1]) begin
            ext = 16'($urandom_range(0, 65535));
            stream.push_back(ext[7:0]);
            stream.push_back(ext[15:8]);
            e.ad = ext[9:0];
            exp_q.push_back(e);
         end else if (op <= 3'd3) begin
            exp_q.push_back(e);
         end else if (op == 3'd4 || op == 3'd5) begin
            n_retire_only++;
         end else begin
            n_illegal++;
         end
      end
      exp_total = retired + n_retire_only + exp_q.size();
      timer = 0; cyc = 0;
      while (cyc < 5000 && !(stream.size() == 0 && rp == wp && exp_q.size() == 0
                             && timer == 0 && !halted && !exec_done)) begin
         tick();
         cyc++;
         exec_done = 1'b0;
         if (timer > 0) begin
            timer--;
            if (timer == 0) exec_done = 1'b1;
         end
         resume    = halted;
         cmd_ready = 1'($urandom_range(0, 1));
         if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
               check("rnd_extra_cmd", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("rnd_opcode", 32'(cmd_opcode),  32'(e.op));
               check("rnd_flags",  32'(cmd_flags),   32'(e.fl));
               check("rnd_addr",   32'(cmd_address), 32'(e.ad));
               $display("TXN op=%0d flags=%0d addr=0x%03h", cmd_opcode, cmd_flags, cmd_address);
            end
            timer = $urandom_range(1, 5);
         end
         if (stream.size() != 0 && $urandom_range(0, 1) == 1) push(stream.pop_front());
      end
      exec_done = 1'b0; resume = 1'b0; cmd_ready = 1'b0;
      tick(2);
      retired = exp_total;
      check("rnd_budget",  32'(cyc < 5000),      32'd1);
      check("rnd_err_ill", 32'(err_illegal),     32'(n_illegal > 0));
      check("rnd_err_to",  32'(err_timeout),     32'd0);
      check("rnd_valid",   32'(cmd_valid),       32'd0);
      check("rnd_busy",    32'(busy),            32'd1);
      check_count("rnd_count");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
